// File: rtl/decoder_5to32_reg.sv
// decoder_5to32_reg: registered 5-to-32 one-hot decoder used as the
// register-file write-select generator (one LOAD enable per register).
// The select index is predecoded in two levels: I[1:0] into 4 lines and
// I[4:2] into 8 lines. The two are ANDed into 32 lines, gated by EN, and
// registered.
// Optional build macro DECODER_VALID_OUT_EN adds the registered VALID and
// Q_IDX outputs. Q_IDX holds its last value while EN is low.
module decoder_5to32_reg (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  I,
    input  logic        EN,
`ifdef DECODER_VALID_OUT_EN
    output logic        VALID,
    output logic [4:0]  Q_IDX,
`endif
    output logic [31:0] D
);

    logic [3:0]  low_dec;
    logic [7:0]  high_dec;
    logic [31:0] d_d;
    logic [31:0] d_q;

    // Two-level predecode of the index, combined into the gated 32-line word
    always_comb begin
        low_dec  = 4'b0001 << I[1:0];
        high_dec = 8'b0000_0001 << I[4:2];
        d_d      = '0;
        if (EN) begin
            d_d = {high_dec[7] ? low_dec : 4'b0000,
                   high_dec[6] ? low_dec : 4'b0000,
                   high_dec[5] ? low_dec : 4'b0000,
                   high_dec[4] ? low_dec : 4'b0000,
                   high_dec[3] ? low_dec : 4'b0000,
                   high_dec[2] ? low_dec : 4'b0000,
                   high_dec[1] ? low_dec : 4'b0000,
                   high_dec[0] ? low_dec : 4'b0000};
        end
    end

    // Output register; reset clears it so the word is never multi-hot
    always_ff @(posedge CLK) begin
        if (RESET) begin
            d_q <= '0;
        end else begin
            d_q <= d_d;
        end
    end

    assign D = d_q;

`ifdef DECODER_VALID_OUT_EN
    logic       valid_d;
    logic       valid_q;
    logic [4:0] q_idx_d;
    logic [4:0] q_idx_q;

    // Sideband next-state: VALID follows EN and the index is captured only when enabled
    always_comb begin
        valid_d = EN;
        q_idx_d = q_idx_q;
        if (EN) begin
            q_idx_d = I;
        end
    end

    // Sideband registers share timing with the decode word
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= 1'b0;
            q_idx_q <= '0;
        end else begin
            valid_q <= valid_d;
            q_idx_q <= q_idx_d;
        end
    end

    assign VALID = valid_q;
    assign Q_IDX = q_idx_q;
`endif

endmodule

// File: tb/tb_decoder_5to32_reg.sv
// tb_decoder_5to32_reg: directed and randomized checks of decoder_5to32_reg
// against a behavioural model of the registered one-hot decode.
// Optional build macro DECODER_VALID_OUT_EN also checks VALID and Q_IDX.
module tb_decoder_5to32_reg;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [4:0]  I;
    logic        EN;
    logic [31:0] D;
`ifdef DECODER_VALID_OUT_EN
    logic        VALID;
    logic [4:0]  Q_IDX;
`endif

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_d;
    logic        model_valid = 1'b0;
`ifdef DECODER_VALID_OUT_EN
    logic        exp_valid;
    logic [4:0]  exp_qidx;
`endif

    decoder_5to32_reg dut (
        .CLK   (CLK),
        .RESET (RESET),
        .I     (I),
        .EN    (EN),
`ifdef DECODER_VALID_OUT_EN
        .VALID (VALID),
        .Q_IDX (Q_IDX),
`endif
        .D     (D)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 CLK = ~CLK;

    // The word with only bit k set, built bit by bit rather than by shifting
    function automatic logic [31:0] hotWord(input int k);
        logic [31:0] w;
        w = '0;
        for (int b = 0; b < 32; b++) begin
            if (b == k) w[b] = 1'b1;
        end
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge, then wait until just after the sampling edge
    task automatic applyStimulus(input logic rst, input logic en, input int idx);
        @(negedge CLK);
        RESET = rst;
        EN    = en;
        I     = 5'(idx);
        @(posedge CLK);
        #1;
    endtask

    // Reference model: what the outputs must hold after each rising edge
    always @(posedge CLK) begin
        exp_d       <= (!RESET && EN) ? hotWord(int'(I)) : 32'h0;
        model_valid <= 1'b1;
`ifdef DECODER_VALID_OUT_EN
        exp_valid   <= !RESET && EN;
        if (RESET)   exp_qidx <= 5'd0;
        else if (EN) exp_qidx <= I;
`endif
    end

    // Every falling edge: outputs against the model, plus the at-most-one-hot invariant
    always @(negedge CLK) begin
        if (model_valid) begin
            checkOutput("model_d", D, exp_d);
            checkOutput("popcount_le1", {31'b0, ($countones(D) > 1)}, 32'h0);
`ifdef DECODER_VALID_OUT_EN
            checkOutput("model_valid", {31'b0, VALID}, {31'b0, exp_valid});
            checkOutput("model_qidx", {27'b0, Q_IDX}, {27'b0, exp_qidx});
`endif
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RESET = 1'b1;
        EN    = 1'b1;
        I     = 5'd5;

        // Reset held two cycles with EN=1, I=5
        applyStimulus(1'b1, 1'b1, 5);
        checkOutput("reset_cycle1", D, 32'h0000_0000);
        applyStimulus(1'b1, 1'b1, 5);
        checkOutput("reset_cycle2", D, 32'h0000_0000);
        applyStimulus(1'b0, 1'b1, 5);
        checkOutput("after_reset_i5", D, 32'h0000_0020);

        // Full sweep 0..31 then wrap to 0
        for (int k = 0; k < 32; k++) begin
            applyStimulus(1'b0, 1'b1, k);
            checkOutput("sweep", D, hotWord(k));
        end
        checkOutput("sweep_end_i31", D, 32'h8000_0000);
        applyStimulus(1'b0, 1'b1, 0);
        checkOutput("wrap_i0", D, 32'h0000_0001);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("map_i1", D, 32'h0000_0002);
        applyStimulus(1'b0, 1'b1, 15);
        checkOutput("map_i15", D, 32'h0000_8000);
        applyStimulus(1'b0, 1'b1, 16);
        checkOutput("map_i16", D, 32'h0001_0000);

        // Enable gating with I=9
        applyStimulus(1'b0, 1'b1, 9);
        checkOutput("gate_en1", D, 32'h0000_0200);
        applyStimulus(1'b0, 1'b0, 9);
        checkOutput("gate_en0", D, 32'h0000_0000);
        applyStimulus(1'b0, 1'b1, 9);
        checkOutput("gate_en1_again", D, 32'h0000_0200);

        // Input change mid-cycle must not reach D before the next edge
        applyStimulus(1'b0, 1'b1, 3);
        checkOutput("latency_i3", D, 32'h0000_0008);
        #2;
        I = 5'd4;
        #1;
        checkOutput("latency_hold", D, 32'h0000_0008);
        @(posedge CLK);
        #1;
        checkOutput("latency_i4", D, 32'h0000_0010);

        // Reset in the middle of a sweep at I=20
        for (int k = 17; k < 20; k++) begin
            applyStimulus(1'b0, 1'b1, k);
            checkOutput("midsweep", D, hotWord(k));
        end
        applyStimulus(1'b1, 1'b1, 20);
        checkOutput("midsweep_reset", D, 32'h0000_0000);
        applyStimulus(1'b0, 1'b1, 21);
        checkOutput("midsweep_resume", D, 32'h0020_0000);

`ifdef DECODER_VALID_OUT_EN
        // Sideband: capture of index 31, then held while disabled
        applyStimulus(1'b0, 1'b1, 31);
        checkOutput("side_d31", D, 32'h8000_0000);
        checkOutput("side_valid1", {31'b0, VALID}, 32'h1);
        checkOutput("side_qidx31", {27'b0, Q_IDX}, 32'd31);
        applyStimulus(1'b0, 1'b0, 7);
        checkOutput("side_d0", D, 32'h0000_0000);
        checkOutput("side_valid0", {31'b0, VALID}, 32'h0);
        checkOutput("side_qidx_hold", {27'b0, Q_IDX}, 32'd31);
`endif

        // Randomized traffic checked by the model process
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                          int'($urandom_range(0, 31)));
        end

        @(negedge CLK);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
